// File: rtl/instr_stream_encoder.sv
// Streaming mini-MIPS instruction encoder: packs field bundles into 32-bit words
// and writes them to instruction memory at consecutive word addresses.
module instr_stream_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  // Handshake: a beat transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on state, never on in_valid; beats are never stalled.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_unsupported,
  output logic              err_overflow,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic [ADDR_W:0]     word_count_q;
  logic                err_unsup_q;
  logic                err_ovf_q;

  logic                enc_ok_d;
  logic [31:0]         enc_word_d;
  logic                accept;
  logic                room;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'(DEPTH);

  assign accept = in_valid && (state_q == LOAD);
  assign room   = (word_count_q < CAP);

  // Opcode/funct classification mirrors the decoder's map exactly.
  always_comb begin
    enc_ok_d   = 1'b1;
    enc_word_d = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
    case (in_opcode)
      6'b000000: begin
        case (in_funct)
          6'b100000, 6'b100010, 6'b100001, 6'b100011, 6'b111100, 6'b111101,
          6'b011000, 6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b101010,
          6'b101011:
            enc_word_d = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
          6'b000000, 6'b000010, 6'b000011, 6'b000100:
            enc_word_d = {in_opcode, 5'd0, in_rt, in_rd, in_shamt, in_funct};
          6'b001000:
            enc_word_d = {in_opcode, in_rs, 15'd0, in_funct};
          default: enc_ok_d = 1'b0;
        endcase
      end
      6'b000010, 6'b000011:
        enc_word_d = {in_opcode, in_target};
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
      6'b001110, 6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b100000,
      6'b101000:
        enc_word_d = {in_opcode, in_rs, in_rt, in_imm16};
      6'b001111:
        enc_word_d = {in_opcode, 5'd0, in_rt, in_imm16};
      6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100, 6'b110101,
      6'b110110, 6'b110111:
        enc_word_d = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
      default: enc_ok_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE;
      imem_wdata_q <= 32'd0;
      word_count_q <= '0;
      err_unsup_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= LOAD;
            word_count_q <= '0;
            err_unsup_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (!enc_ok_d) begin
              err_unsup_q <= 1'b1;
            end else if (room) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= BASE + word_count_q[ADDR_W-1:0];
              imem_wdata_q <= enc_word_d;
              word_count_q <= word_count_q + (ADDR_W+1)'(1);
            end else begin
              err_ovf_q <= 1'b1;
            end
            // Session closes on the last beat even if that beat was dropped.
            if (in_last) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready        = (state_q == LOAD);
  assign busy            = (state_q == LOAD);
  assign done            = (state_q == DONE);
  assign imem_we         = imem_we_q;
  assign imem_addr       = imem_addr_q;
  assign imem_wdata      = imem_wdata_q;
  assign word_count      = word_count_q;
  assign err_unsupported = err_unsup_q;
  assign err_overflow    = err_ovf_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: a default instance plus a small
// DEPTH=4, BASE_ADDR=0xFE instance for address wrap and overflow.
module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        in_valid, in_last;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm16;
  logic [25:0] in_target;

  logic        a_ready, a_we, a_busy, a_done, a_eu, a_eo;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_wc;
  logic [1:0]  a_st;

  logic        b_ready, b_we, b_busy, b_done, b_eu, b_eo;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic [8:0]  b_wc;
  logic [1:0]  b_st;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_stream_encoder dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(a_ready),
    .in_last(in_last), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm16(in_imm16),
    .in_target(in_target), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .word_count(a_wc), .err_unsupported(a_eu),
    .err_overflow(a_eo), .state_dbg(a_st)
  );

  instr_stream_encoder #(.ADDR_W(8), .BASE_ADDR(8'hFE), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(b_ready),
    .in_last(in_last), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm16(in_imm16),
    .in_target(in_target), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .word_count(b_wc), .err_unsupported(b_eu),
    .err_overflow(b_eo), .state_dbg(b_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit which_b);
    @(negedge clk);
    in_valid = 1'b0;
    if (which_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic beat(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input bit last);
    @(negedge clk);
    in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm16 = imm; in_target = tgt;
    in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic add_beat(input bit last);
    beat(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0, last);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm16 = '0; in_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_we", a_we, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_errs", {a_eu, a_eo}, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_wc", a_wc, 0);
    chk("rst_addr_b", b_addr, 32'hFE);
    chk("rst_state", a_st, 0);
    @(negedge clk); rst = 1'b0;

    // Single add, last beat
    pulse_start(1'b0);
    chk("start_busy", a_busy, 1);
    chk("start_ready", a_ready, 1);
    add_beat(1'b1);
    chk("add_we", a_we, 1);
    chk("add_addr", a_addr, 0);
    chk("add_wdata", a_wdata, 32'h00221820);
    chk("add_done", a_done, 1);
    chk("add_busy", a_busy, 0);
    chk("add_wc", a_wc, 1);
    tick();
    chk("add_we_drop", a_we, 0);
    chk("add_done_hold", a_done, 1);

    // Back-to-back addi / lw / j, with a start during LOAD that must be ignored
    pulse_start(1'b0);
    beat(6'b001000, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0, 1'b0);
    chk("b2b0_we", a_we, 1);
    chk("b2b0_addr", a_addr, 0);
    chk("b2b0_wdata", a_wdata, 32'h20850010);
    start_a = 1'b1;
    beat(6'b100000, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0, 1'b0);
    start_a = 1'b0;
    chk("b2b1_we", a_we, 1);
    chk("b2b1_addr", a_addr, 1);
    chk("b2b1_wdata", a_wdata, 32'h81280004);
    beat(6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000100, 1'b1);
    chk("b2b2_we", a_we, 1);
    chk("b2b2_addr", a_addr, 2);
    chk("b2b2_wdata", a_wdata, 32'h08000100);
    chk("b2b_wc", a_wc, 3);
    chk("b2b_done", a_done, 1);

    // Field forcing and pass-through encodings
    pulse_start(1'b0);
    beat(6'b000000, 5'd7, 5'd1, 5'd2, 5'd4, 6'b000000, 16'h0, 26'h0, 1'b0);
    chk("sll_wdata", a_wdata, 32'h00011100);
    beat(6'b000000, 5'd31, 5'd5, 5'd6, 5'd3, 6'b001000, 16'h0, 26'h0, 1'b0);
    chk("jr_wdata", a_wdata, 32'h03E00008);
    beat(6'b001111, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hABCD, 26'h0, 1'b0);
    chk("lui_wdata", a_wdata, 32'h3C04ABCD);
    beat(6'b110001, 5'd1, 5'd2, 5'd3, 5'd4, 6'b000101, 16'h0, 26'h0, 1'b1);
    chk("fp_wdata", a_wdata, 32'hC4221905);
    chk("fp_addr", a_addr, 3);
    chk("fp_wc", a_wc, 4);

    // Unsupported opcode and funct, then add
    pulse_start(1'b0);
    beat(6'b111111, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0, 1'b0);
    chk("unsup_op_we", a_we, 0);
    chk("unsup_op_err", a_eu, 1);
    chk("unsup_op_wc", a_wc, 0);
    beat(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b111111, 16'h0, 26'h0, 1'b0);
    chk("unsup_fn_we", a_we, 0);
    add_beat(1'b1);
    chk("unsup_add_we", a_we, 1);
    chk("unsup_add_addr", a_addr, 0);
    chk("unsup_wc", a_wc, 1);
    chk("unsup_sticky", a_eu, 1);
    chk("unsup_no_ovf", a_eo, 0);

    // Overflow and address wrap on the DEPTH=4 instance
    pulse_start(1'b1);
    add_beat(1'b0);
    chk("ovf0_addr", {b_we, 23'd0, b_addr}, {1'b1, 23'd0, 8'hFE});
    add_beat(1'b0);
    chk("ovf1_addr", {b_we, 23'd0, b_addr}, {1'b1, 23'd0, 8'hFF});
    add_beat(1'b0);
    chk("ovf2_addr", {b_we, 23'd0, b_addr}, {1'b1, 23'd0, 8'h00});
    add_beat(1'b0);
    chk("ovf3_addr", {b_we, 23'd0, b_addr}, {1'b1, 23'd0, 8'h01});
    chk("ovf3_flag", b_eo, 0);
    add_beat(1'b0);
    chk("ovf4_we", b_we, 0);
    chk("ovf4_flag", b_eo, 1);
    add_beat(1'b1);
    chk("ovf5_we", b_we, 0);
    chk("ovf_wc", b_wc, 4);
    chk("ovf_done", b_done, 1);
    chk("ovf_a_idle_we", a_we, 0);

    // New session clears sticky flags; reset mid-session cancels the write
    pulse_start(1'b0);
    chk("restart_err", a_eu, 0);
    chk("restart_wc", a_wc, 0);
    add_beat(1'b0);
    add_beat(1'b0);
    chk("rst2_we", a_we, 1);
    chk("rst2_addr", a_addr, 1);
    rst = 1'b1;
    add_beat(1'b0);
    chk("midrst_we", a_we, 0);
    chk("midrst_state", a_st, 0);
    chk("midrst_wc", a_wc, 0);
    chk("midrst_ready", a_ready, 0);
    chk("midrst_addr_b", b_addr, 32'hFE);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1;
    chk("start_rst_busy", a_busy, 0);
    @(negedge clk); rst = 1'b0; start_a = 1'b0;
    pulse_start(1'b0);
    add_beat(1'b1);
    chk("resume_we", a_we, 1);
    chk("resume_addr", a_addr, 0);
    chk("resume_wc", a_wc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Streaming instruction encoder and loader for the mini-MIPS core: the inverse of the instruction decoder. It accepts one instruction per handshake as separate fields (opcode, rs, rt, rd, shamt, funct, imm16, target). It packs each into a 32-bit word using the same field layout and opcode/funct map the decoder uses, and writes the word into instruction memory at consecutive word addresses. It sits between the test/boot loader and the instruction-memory write port.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.
- `DEPTH`, 256: maximum words per load session; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; opens a load session.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept.
- `in_last`  in  1  marks final instruction of the session.
- `in_opcode`  in  6  opcode field.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register and shift fields.
- `in_funct`  in  6  funct field.
- `in_imm16`  in  16  I-type immediate.
- `in_target`  in  26  J-type target.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `busy`  out  1  high in LOAD.
- `done`  out  1  high in DONE.
- `word_count`  out  ADDR_W+1  words written this session.
- `err_unsupported`  out  1  sticky; an unencodable instruction was seen.
- `err_overflow`  out  1  sticky; a beat arrived after DEPTH words.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE with `start`: go to LOAD. Clear `word_count` and both error flags. Set the address pointer to BASE_ADDR.
  - `start` in LOAD is ignored.
- `in_ready` is 1 only in LOAD. It is never throttled; overflow beats are dropped, not stalled.
- Accept = `in_valid & in_ready`. Every accepted beat is classified by opcode:
  - 000000 (R): word = {op, rs, rt, rd, shamt, funct}.
    - Legal funct values: 100000, 100010, 100001, 100011, 111100, 111101, 011000, 100100, 100101, 100111, 100110, 101010, 101011, 000000, 000010, 000011, 000100, 001000.
    - Shifts (000000, 000010, 000011, 000100) force rs = 0.
    - jr (001000) forces rt, rd and shamt to 0.
    - Any other funct is unsupported.
  - 000010, 000011 (J): word = {op, target}.
  - I-type: word = {op, rs, rt, imm16}.
    - Opcodes: 001000–001011, 001100, 001101, 001110, 001111, 000100–000111, 100000, 101000.
    - lui (001111) forces rs = 0.
  - 110000–110111 (FP): word = {op, rs, rt, rd, shamt, funct}, fields passed through.
  - Any other opcode is unsupported.
- Unsupported beat: accepted, no write, `err_unsupported` set, `word_count` unchanged.
- Supported beat with `word_count` < DEPTH:
  - registered write of `imem_wdata` at `imem_addr` = BASE_ADDR + `word_count` (mod 2^ADDR_W);
  - `word_count` increments.
- Supported beat with `word_count` == DEPTH: no write, `err_overflow` set.
- Accepted beat with `in_last`: go to DONE on the same edge, whether or not that beat was written.
- DONE holds `word_count` and the error flags until the next `start`.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`, `imem_we`, `busy`, `done`, both error flags all 0;
  - `imem_addr` = BASE_ADDR, `imem_wdata` = 0, `word_count` = 0.
- `start` at edge N: `busy`/`in_ready` are 1 in cycle N+1.
- Beat accepted at edge N:
  - `imem_we`, `imem_addr`, `imem_wdata` are valid for exactly cycle N+1;
  - `word_count` reflects the increment in cycle N+1.
- Throughput is one instruction per cycle; back-to-back beats give contiguous `imem_we` pulses with incrementing address.
- Last beat accepted at edge N: `done` = 1 and `busy` = 0 from cycle N+1, concurrent with the final `imem_we`.
- Error flags assert in the cycle after the offending beat.
- `rst` mid-session: at the next edge all outputs return to reset values and any pending write is cancelled (`imem_we` = 0).
- `start` coincident with `rst`: `rst` wins.

## Test plan
- add: start; beat op=0, rs=1, rt=2, rd=3, shamt=0, funct=100000, last=1 → one cycle later `imem_we`=1, addr=0, wdata=0x00221820; then `done`=1, `word_count`=1.
- Three back-to-back beats:
  - addi rs=4, rt=5, imm=0x0010;
  - lw rs=9, rt=8, imm=4;
  - j target=0x0000100.
  - Required: consecutive writes 0x20850010@0, 0x81280004@1, 0x08000100@2.
- Field forcing: sll with rs=7, rt=1, rd=2, shamt=4 → wdata 0x00011100 (rs zeroed).
- Unsupported: opcode 111111, then add → `err_unsupported`=1; only the add is written, at addr 0; `word_count`=1.
- Overflow with DEPTH=4, BASE_ADDR=0xFE, ADDR_W=8:
  - six supported beats → writes at FE, FF, 00, 01;
  - beats 5–6 dropped;
  - `err_overflow`=1, `word_count`=4.
- Assert `rst` in the cycle after acceptance of beat 2 of 5 → `imem_we`=0 next cycle, state IDLE, `word_count`=0; a new `start` resumes writing at BASE_ADDR.
